// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - shared state, opcode, bus and ALU encodings for the SAP-1 sequencer
package sap1_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_PC   = 3'd1;
  localparam logic [2:0] BUS_RAM  = 3'd2;
  localparam logic [2:0] BUS_IR   = 3'd3;
  localparam logic [2:0] BUS_ACC  = 3'd4;
  localparam logic [2:0] BUS_ALU  = 3'd5;

  localparam logic [2:0] ALU_HOLD = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_MUL  = 3'b011;
  localparam logic [2:0] ALU_DIV  = 3'b100;
  localparam logic [2:0] ALU_AND  = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_XOR  = 3'b111;

  // Opcodes 0001..0111 carry their ALU operation directly in the low three bits.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op[3] == 1'b0) && (op[2:0] != 3'b000);
  endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// rtl/sap1_ring_counter.sv - IDLE/T1..T6/HALT timing-state register for the SAP-1 sequencer
module sap1_ring_counter
  import sap1_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   run,
  input  logic   halt_req,
  output state_t state
);

  state_t next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next;
  end

  // halt_req is only meaningful in T4 (HLT) and T6 (divide by zero).
  always_comb begin
    next = state;
    case (state)
      S_IDLE:  if (run) next = S_T1;
      S_T1:    next = S_T2;
      S_T2:    next = S_T3;
      S_T3:    next = S_T4;
      S_T4:    next = halt_req ? S_HALT : S_T5;
      S_T5:    next = S_T6;
      S_T6:    next = halt_req ? S_HALT : S_T1;
      S_HALT:  next = S_HALT;
      default: next = S_IDLE;
    endcase
  end

endmodule

// File: rtl/sap1_control_sequencer.sv
// rtl/sap1_control_sequencer.sv - SAP-1 control sequencer: timing states decoded into datapath strobes
module sap1_control_sequencer
  import sap1_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] ir_opcode,
  input  logic       b_zero,
  output logic       pc_inc,
  output logic       mar_load,
  output logic       ir_load,
  output logic       acc_load,
  output logic       b_load,
  output logic       out_load,
  output logic [2:0] bus_sel,
  output logic [2:0] alu_ctrl,
  output logic       halted,
  output logic       err_div0
);

  state_t state;
  logic   alu_op;
  logic   div_fault;
  logic   halt_req;

  assign alu_op    = is_alu_op(ir_opcode);
  assign div_fault = (state == S_T6) && (ir_opcode == OP_DIV) && b_zero;
  assign halt_req  = ((state == S_T4) && (ir_opcode == OP_HLT)) || div_fault;
  assign halted    = (state == S_HALT);

  sap1_ring_counter u_ring (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .halt_req (halt_req),
    .state    (state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            err_div0 <= 1'b0;
    else if (div_fault) err_div0 <= 1'b1;
  end

  // Strobes depend only on registered state and the opcode, never on run.
  always_comb begin
    pc_inc   = 1'b0;
    mar_load = 1'b0;
    ir_load  = 1'b0;
    acc_load = 1'b0;
    b_load   = 1'b0;
    out_load = 1'b0;
    bus_sel  = BUS_NONE;
    alu_ctrl = ALU_HOLD;
    case (state)
      S_T1: begin bus_sel = BUS_PC;  mar_load = 1'b1; end
      S_T2: pc_inc = 1'b1;
      S_T3: begin bus_sel = BUS_RAM; ir_load = 1'b1; end
      S_T4: begin
        if (ir_opcode == OP_LDA || alu_op) begin
          bus_sel  = BUS_IR;
          mar_load = 1'b1;
        end else if (ir_opcode == OP_OUT) begin
          bus_sel  = BUS_ACC;
          out_load = 1'b1;
        end
      end
      S_T5: begin
        if (ir_opcode == OP_LDA) begin
          bus_sel  = BUS_RAM;
          acc_load = 1'b1;
        end else if (alu_op) begin
          bus_sel = BUS_RAM;
          b_load  = 1'b1;
        end
      end
      S_T6: begin
        if (alu_op && !div_fault) begin
          bus_sel  = BUS_ALU;
          acc_load = 1'b1;
          alu_ctrl = ir_opcode[2:0];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sap1_control_sequencer.sv
// tb/tb_sap1_control_sequencer.sv - vector table, corner sequences and random model check of the sequencer
module tb_sap1_control_sequencer;

  logic       clk = 1'b0;
  logic       rst, run, b_zero;
  logic [3:0] ir_opcode;
  logic       pc_inc, mar_load, ir_load, acc_load, b_load, out_load;
  logic [2:0] bus_sel, alu_ctrl;
  logic       halted, err_div0;

  always #5 clk = ~clk;

  sap1_control_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .ir_opcode (ir_opcode),
    .b_zero    (b_zero),
    .pc_inc    (pc_inc),
    .mar_load  (mar_load),
    .ir_load   (ir_load),
    .acc_load  (acc_load),
    .b_load    (b_load),
    .out_load  (out_load),
    .bus_sel   (bus_sel),
    .alu_ctrl  (alu_ctrl),
    .halted    (halted),
    .err_div0  (err_div0)
  );

  // {pc_inc, mar, ir, acc, b, out, bus_sel[2:0], alu_ctrl[2:0], halted, err_div0}
  logic [13:0] act;
  assign act = {pc_inc, mar_load, ir_load, acc_load, b_load, out_load,
                bus_sel, alu_ctrl, halted, err_div0};

  localparam logic [13:0] Z    = 14'b0;
  localparam logic [13:0] FT1  = {6'b010000, 3'd1, 3'd0, 2'b00};
  localparam logic [13:0] FT2  = {6'b100000, 3'd0, 3'd0, 2'b00};
  localparam logic [13:0] FT3  = {6'b001000, 3'd2, 3'd0, 2'b00};
  localparam logic [13:0] ADR  = {6'b010000, 3'd3, 3'd0, 2'b00};
  localparam logic [13:0] BRD  = {6'b000010, 3'd2, 3'd0, 2'b00};
  localparam logic [13:0] LDA5 = {6'b000100, 3'd2, 3'd0, 2'b00};
  localparam logic [13:0] OUT4 = {6'b000001, 3'd4, 3'd0, 2'b00};
  localparam logic [13:0] ADD6 = {6'b000100, 3'd5, 3'd1, 2'b00};
  localparam logic [13:0] SUB6 = {6'b000100, 3'd5, 3'd2, 2'b00};
  localparam logic [13:0] DIV6 = {6'b000100, 3'd5, 3'd4, 2'b00};
  localparam logic [13:0] HLTD = {6'b000000, 3'd0, 3'd0, 2'b10};
  localparam logic [13:0] DIVH = {6'b000000, 3'd0, 3'd0, 2'b11};

  typedef struct {
    logic        r;
    logic        rn;
    logic [3:0]  op;
    logic        bz;
    logic [13:0] want;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic add(input logic r, input logic rn, input logic [3:0] op,
                     input logic bz, input logic [13:0] want);
    vec_t v;
    v.r = r; v.rn = rn; v.op = op; v.bz = bz; v.want = want;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  task automatic drive(input logic r, input logic rn, input logic [3:0] op, input logic bz);
    rst = r; run = rn; ir_opcode = op; b_zero = bz;
  endtask

  task automatic cyc(input logic r, input logic rn, input logic [3:0] op, input logic bz,
                     input logic [13:0] want, input string name);
    drive(r, rn, op, bz);
    @(negedge clk);
    check(name, act, want);
    @(posedge clk);
    #1;
  endtask

  // Reference model: step 0 idle, 1..6 = T1..T6, 7 halted; outputs from a per-opcode micro-op table.
  int   m_step;
  logic m_err;

  function automatic logic [13:0] model_out(input int step, input logic [3:0] op,
                                            input logic bz, input logic e);
    logic is_alu, is_lda, is_out;
    logic [13:0] o;
    is_lda = (op == 4'd0);
    is_alu = (op >= 4'd1) && (op <= 4'd7);
    is_out = (op == 4'hE);
    o = Z;
    case (step)
      1: o = FT1;
      2: o = FT2;
      3: o = FT3;
      4: o = (is_lda || is_alu) ? ADR : (is_out ? OUT4 : Z);
      5: o = is_lda ? LDA5 : (is_alu ? BRD : Z);
      6: if (is_alu && !(op == 4'd4 && bz)) o = {6'b000100, 3'd5, op[2:0], 2'b00};
      7: o = HLTD;
      default: o = Z;
    endcase
    o[0] = e;
    return o;
  endfunction

  task automatic model_advance(input logic r, input logic rn, input logic [3:0] op, input logic bz);
    if (r) begin
      m_step = 0; m_err = 1'b0;
    end else if (m_step == 0) begin
      m_step = rn ? 1 : 0;
    end else if (m_step == 7) begin
      m_step = 7;
    end else if (m_step == 4 && op == 4'hF) begin
      m_step = 7;
    end else if (m_step == 6 && op == 4'd4 && bz) begin
      m_step = 7; m_err = 1'b1;
    end else begin
      m_step = (m_step % 6) + 1;
    end
  endtask

  initial begin
    logic       r, rn, bz;
    logic [3:0] op;
    drive(1'b1, 1'b0, 4'd0, 1'b0);

    // ADD, then DIV by zero to HALT
    add(1,0,4'h1,0,Z);    add(0,1,4'h1,0,Z);
    add(0,0,4'h1,0,FT1);  add(0,0,4'h1,0,FT2);  add(0,0,4'h1,0,FT3);
    add(0,0,4'h1,0,ADR);  add(0,0,4'h1,0,BRD);  add(0,0,4'h1,0,ADD6);
    add(0,0,4'h4,1,FT1);  add(0,0,4'h4,1,FT2);  add(0,0,4'h4,1,FT3);
    add(0,0,4'h4,1,ADR);  add(0,0,4'h4,1,BRD);  add(0,0,4'h4,1,Z);
    add(0,1,4'h4,1,DIVH); add(0,0,4'h4,0,DIVH); add(0,1,4'h4,0,DIVH);
    // OUT, NOP with run low, LDA, SUB with b_zero, DIV with nonzero B
    add(1,0,4'hE,0,Z);    add(0,1,4'hE,0,Z);
    add(0,0,4'hE,0,FT1);  add(0,0,4'hE,0,FT2);  add(0,0,4'hE,0,FT3);
    add(0,0,4'hE,0,OUT4); add(0,0,4'hE,0,Z);    add(0,0,4'hE,0,Z);
    add(0,0,4'hA,0,FT1);  add(0,0,4'hA,0,FT2);  add(0,0,4'hA,0,FT3);
    add(0,0,4'hA,0,Z);    add(0,0,4'hA,0,Z);    add(0,0,4'hA,0,Z);
    add(0,0,4'h0,0,FT1);  add(0,0,4'h0,0,FT2);  add(0,0,4'h0,0,FT3);
    add(0,0,4'h0,0,ADR);  add(0,0,4'h0,0,LDA5); add(0,0,4'h0,0,Z);
    add(0,0,4'h2,1,FT1);  add(0,0,4'h2,1,FT2);  add(0,0,4'h2,1,FT3);
    add(0,0,4'h2,1,ADR);  add(0,0,4'h2,1,BRD);  add(0,0,4'h2,1,SUB6);
    add(0,0,4'h4,0,FT1);  add(0,0,4'h4,0,FT2);  add(0,0,4'h4,0,FT3);
    add(0,0,4'h4,0,ADR);  add(0,0,4'h4,0,BRD);  add(0,0,4'h4,0,DIV6);
    add(0,0,4'h4,0,FT1);

    @(posedge clk);
    #1;
    foreach (vecs[i])
      cyc(vecs[i].r, vecs[i].rn, vecs[i].op, vecs[i].bz, vecs[i].want, $sformatf("vec%0d", i));

    // HLT: halts after T4, ignores run, leaves only on rst
    cyc(1,0,4'hF,0,Z,"hlt_rst");
    cyc(0,1,4'hF,0,Z,"hlt_idle");
    cyc(0,0,4'hF,0,FT1,"hlt_t1");
    cyc(0,0,4'hF,0,FT2,"hlt_t2");
    cyc(0,0,4'hF,0,FT3,"hlt_t3");
    cyc(0,0,4'hF,0,Z,"hlt_t4");
    for (int i = 0; i < 4; i++)
      cyc(0, i[0], 4'h1, 0, HLTD, "hlt_stay");
    cyc(1,1,4'h1,0,Z,"hlt_rst_exit");
    cyc(0,0,4'h1,0,Z,"post_rst_idle");
    cyc(0,0,4'h1,0,Z,"post_rst_idle");

    // Reset asserted mid-T5 of SUB
    cyc(0,1,4'h2,0,Z,"mr_idle");
    cyc(0,0,4'h2,0,FT1,"mr_t1");
    cyc(0,0,4'h2,0,FT2,"mr_t2");
    cyc(0,0,4'h2,0,FT3,"mr_t3");
    cyc(0,0,4'h2,0,ADR,"mr_t4");
    drive(1'b0, 1'b0, 4'h2, 1'b0);
    @(negedge clk);
    check("mr_t5", act, BRD);
    #2 rst = 1'b1;
    #1 check("mr_async", act, Z);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cyc(0,0,4'h2,0,Z,"mr_no_bload");
    cyc(0,1,4'h2,0,Z,"mr_restart");
    cyc(0,0,4'h2,0,FT1,"mr_new_t1");
    cyc(0,0,4'h2,0,FT2,"mr_new_t2");
    cyc(0,0,4'h2,0,FT3,"mr_new_t3");
    cyc(0,0,4'h2,0,ADR,"mr_new_t4");
    cyc(0,0,4'h2,0,BRD,"mr_new_t5");

    // Randomized run against the reference model
    m_step = 0;
    m_err  = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (i == 0)           r = 1'b1;
      else if (m_step == 7) r = ($urandom_range(3) == 0);
      else                  r = ($urandom_range(39) == 0);
      rn = 1'($urandom_range(1));
      op = 4'($urandom_range(15));
      bz = 1'($urandom_range(1));
      drive(r, rn, op, bz);
      if (r) begin
        m_step = 0;
        m_err  = 1'b0;
      end
      @(negedge clk);
      check("rand_out", act, model_out(m_step, op, bz, m_err));
      checks++;
      if ($countones(act[13:8]) > 1 || (act[12:8] == 5'b0 && act[7:5] != 3'd0)) begin
        failures++;
        $display("FAIL rand_onehot got=%b want=at most one strobe, bus idle without load", act);
      end
      @(posedge clk);
      model_advance(r, rn, op, bz);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
